// File: rtl/cvmcu_pad_pkg.sv
// Shared types and default parameters for the pad event capture block.
package cvmcu_pad_pkg;

    localparam int DEF_NUM_PADS = 48;
    localparam int DEF_TS_W     = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_CNT_W    = 8;

    // Event payload at default widths; the FIFO word is packed in the same field order.
    typedef struct packed {
        logic [DEF_TS_W-1:0]     ts;
        logic [DEF_NUM_PADS-1:0] out;
        logic [DEF_NUM_PADS-1:0] oe;
    } pad_evt_t;

endpackage

// File: rtl/cvmcu_pad_event_capture_if.sv
// Event stream from the capture block to its consumer (valid/ready with payload).
interface cvmcu_pad_event_capture_if
    import cvmcu_pad_pkg::*;
#(
    parameter int NUM_PADS = DEF_NUM_PADS,
    parameter int TS_W     = DEF_TS_W
);

    logic                evt_valid_o;
    logic                evt_ready_i;
    logic [TS_W-1:0]     evt_ts_o;
    logic [NUM_PADS-1:0] evt_out_o;
    logic [NUM_PADS-1:0] evt_oe_o;

    modport master (
        output evt_valid_o,
        output evt_ts_o,
        output evt_out_o,
        output evt_oe_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_ts_o,
        input  evt_out_o,
        input  evt_oe_o,
        output evt_ready_i
    );

endinterface

// File: rtl/cvmcu_pad_evt_fifo.sv
// Synchronous FIFO; a write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module cvmcu_pad_evt_fifo
    import cvmcu_pad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_ok_s = rd_en && !empty;
        wr_ok_s = wr_en && (!full || rd_ok_s);
        rd_data = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update; reset and clear both empty the FIFO and win over traffic.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Storage array; contents are meaningless outside the pointer window so it is not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cvmcu_pad_event_capture.sv
// Timestamps changes on unmasked pad out/oe values and queues them for a valid/ready consumer.
module cvmcu_pad_event_capture
    import cvmcu_pad_pkg::*;
#(
    parameter int NUM_PADS = DEF_NUM_PADS,
    parameter int TS_W     = DEF_TS_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CNT_W    = DEF_CNT_W
)(
    input  logic                      ref_clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [NUM_PADS-1:0]       mask_i,
    input  logic [NUM_PADS-1:0]       io_out_i,
    input  logic [NUM_PADS-1:0]       io_oe_i,
    cvmcu_pad_event_capture_if.master evt,
    output logic                      overflow_o,
    output logic [CNT_W-1:0]          dropped_o
);

    localparam int EVT_W = TS_W + 2 * NUM_PADS;
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]     ts_r;
    logic [NUM_PADS-1:0] snap_out_r;
    logic [NUM_PADS-1:0] snap_oe_r;
    logic                priming_r;
    logic                overflow_r;
    logic [CNT_W-1:0]    dropped_r;
    logic                change_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic [EVT_W-1:0]    wr_data_s;
    logic [EVT_W-1:0]    rd_data_s;

    // Free-running timestamp, per-cycle snapshot and the priming flag that follows reset/clear.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            ts_r       <= {TS_W{1'b0}};
            snap_out_r <= {NUM_PADS{1'b0}};
            snap_oe_r  <= {NUM_PADS{1'b0}};
            priming_r  <= 1'b1;
        end else begin
            ts_r       <= ts_r + TS_ONE;
            snap_out_r <= io_out_i;
            snap_oe_r  <= io_oe_i;
            priming_r  <= clear_i;
        end
    end

    // Change detection and FIFO handshake decode.
    always_comb begin
        change_s  = 1'b0;
        wr_data_s = {ts_r, io_out_i, io_oe_i};
        if (priming_r) begin
            change_s = 1'b0;
        end else begin
            change_s = |(((io_out_i ^ snap_out_r) | (io_oe_i ^ snap_oe_r)) & ~mask_i);
        end
        push_s = enable_i && change_s && !clear_i;
        pop_s  = evt.evt_ready_i && !empty_s;
    end

    // Sticky overflow and saturating drop counter; a pop in the same cycle makes room, so no drop.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i || clear_i) begin
            overflow_r <= 1'b0;
            dropped_r  <= {CNT_W{1'b0}};
        end else if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
            if (dropped_r != CNT_MAX) dropped_r <= dropped_r + CNT_ONE;
        end
    end

    cvmcu_pad_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ref_clk_i),
        .rst     (rst_i),
        .clr     (clear_i),
        .wr_en   (push_s),
        .wr_data (wr_data_s),
        .rd_en   (pop_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign evt.evt_valid_o = !empty_s;
    assign evt.evt_ts_o    = rd_data_s[EVT_W-1 -: TS_W];
    assign evt.evt_out_o   = rd_data_s[2*NUM_PADS-1 -: NUM_PADS];
    assign evt.evt_oe_o    = rd_data_s[NUM_PADS-1:0];
    assign overflow_o      = overflow_r;
    assign dropped_o       = dropped_r;

endmodule

// File: doc/cvmcu_pad_event_capture.md
CVMCU_PAD_EVENT_CAPTURE -- requirements
Module: cvmcu_pad_event_capture

Interface
REQ-001 SHALL have parameter NUM_PADS, default 48, number of observed pads.
REQ-002 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, event FIFO depth (power of two, >=2).
REQ-004 SHALL have parameter CNT_W, default 8, dropped-event counter width.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port ref_clk_i  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have port enable_i  input  1  event capture enable.
REQ-009 SHALL have port clear_i  input  1  flush FIFO, clear overflow state, re-prime snapshot.
REQ-010 SHALL have port mask_i  input  NUM_PADS  1 = pad ignored for change detection.
REQ-011 SHALL have port io_out_i  input  NUM_PADS  pad output values.
REQ-012 SHALL have port io_oe_i  input  NUM_PADS  pad output enables.
REQ-013 SHALL have port evt_valid_o  output  1  event available.
REQ-014 SHALL have port evt_ready_i  input  1  consumer accepts event.
REQ-015 SHALL have port evt_ts_o  output  TS_W  event timestamp.
REQ-016 SHALL have port evt_out_o  output  NUM_PADS  captured io_out_i.
REQ-017 SHALL have port evt_oe_o  output  NUM_PADS  captured io_oe_i.
REQ-018 SHALL have port overflow_o  output  1  sticky: at least one event dropped.
REQ-019 SHALL have port dropped_o  output  CNT_W  saturating dropped-event count.

Function
REQ-020 SHALL run a free-running TS_W timestamp counter, +1 every cycle, wrapping max->0.
REQ-021 SHALL register io_out_i/io_oe_i every cycle into a snapshot, regardless of enable_i.
REQ-022 SHALL flag a change when any unmasked pad differs from the snapshot in io_out_i or io_oe_i.
REQ-023 SHALL, in the first cycle after reset or clear_i (priming), load the snapshot and flag no change.
REQ-024 SHALL generate an event when enable_i=1 and a change is flagged, with payload {current timestamp, io_out_i, io_oe_i}.
REQ-025 SHALL write the event into the FIFO at the same clock edge; evt_valid_o rises one cycle after the change cycle; no bypass.
REQ-026 SHALL complete a pop when evt_valid_o and evt_ready_i are both high at a clock edge; outputs SHALL be stable while valid is high and ready is low.
REQ-027 SHALL drive evt_ts_o/evt_out_o/evt_oe_o from the FIFO head; the values are don't-care when evt_valid_o=0.
REQ-028 SHALL, on a push with the FIFO full and no pop, drop the event, set overflow_o, and increment dropped_o, saturating at 2^CNT_W-1.
REQ-029 SHALL, on a push and a pop in the same cycle with the FIFO full, accept both; no drop occurs.
REQ-030 SHALL, on a push and a pop in the same cycle with the FIFO empty, ignore the pop; the push is stored.
REQ-031 SHALL make clear_i take priority over push/pop: empty the FIFO, zero overflow_o and dropped_o, enter priming; the timestamp is not affected.
REQ-032 SHALL, when mask_i is all ones, generate no events.

Reset
REQ-033 SHALL, while rst_i=1, set evt_valid_o=0, overflow_o=0, dropped_o=0, timestamp=0, snapshot=0, FIFO pointers=0, priming=1.
REQ-034 SHALL, when reset is asserted mid-operation, discard all stored events at the next edge; no partial pop is visible.

Structure
REQ-035 SHALL place the event payload struct type (ts, out, oe) and default parameter constants in package cvmcu_pad_pkg.
REQ-036 SHALL implement the FIFO as sub-module cvmcu_pad_evt_fifo, a synchronous FIFO parametrised by width and DEPTH, with full/empty outputs.

Verification
REQ-037 SHALL test priming: io_out_i=48'hFFFF held through reset release -> no event; pad 3 toggled at ts=10 -> one event with ts=10, out bit3 flipped, evt_valid_o high at ts=11.
REQ-038 SHALL test masking: mask_i[5]=1, toggle pad 5 -> no event; toggle pad 6 -> one event.
REQ-039 SHALL test overflow: DEPTH=16, evt_ready_i=0, 20 consecutive change cycles -> 16 stored, overflow_o=1, dropped_o=4; then clear_i -> evt_valid_o=0, dropped_o=0.
REQ-040 SHALL test full with simultaneous push/pop: with the FIFO full, evt_ready_i=1 and a change in the same cycle -> count stays 16, dropped_o unchanged.
REQ-041 SHALL test wrap: TS_W=4, event at cycle 17 -> evt_ts_o=1.
REQ-042 SHALL test backpressure and reset: evt_ready_i toggled randomly -> events delivered in order and stable while stalled; rst_i mid-stream -> evt_valid_o=0 the next cycle.
